pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the hold and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers from four sources: load-use hazards, taken branches, a variable-latency data memory, and a fixed-latency multiply/divide unit (MDU). It also watches memory accesses and stops the pipe on a stuck access. Outputs are combinational from registered state plus current-cycle inputs, so every stage register sees its control in the same cycle.

## Interface
- MDU_LAT, 32: MDU busy cycles per started operation (>=1).
- MEM_TO, 255: consecutive memory-wait cycles that count as a timeout (>=1).
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemReqM  in  1  MEM stage holds a load/store this cycle.
- MemRdyM  in  1  data memory completes the access this cycle.
- LoadUseD  in  1  ID instruction needs the result of a load now in EX.
- BranchTakenD  in  1  branch resolved taken in ID.
- MduStartE  in  1  EX stage issues mult/div.
- MduUseD  in  1  ID instruction reads HI/LO.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- FlushD  out  1  clear IF/ID.
- StallE  out  1  hold ID/EX.
- FlushE  out  1  clear ID/EX (bubble).
- StallM  out  1  hold EX/MEM.
- FlushM  out  1  clear EX/MEM.
- FlushW  out  1  clear MEM/WB (RegWriteW=0).
- MduBusy  out  1  MDU counter non-zero.
- MemErr  out  1  sticky memory timeout flag.

## Operation
- States: RUN, MWAIT, ERR. Also a mdu_cnt counter and a to_cnt counter.
- Memory wait condition: mw = MemReqM & ~MemRdyM.
- RUN:
  - mw=1 moves to MWAIT and sets to_cnt=1.
  - mw=0 stays in RUN.
- MWAIT:
  - MemRdyM=1 returns to RUN and clears to_cnt.
  - Otherwise to_cnt increments. When to_cnt reaches MEM_TO, move to ERR and set MemErr.
- ERR: absorbing until reset.
- Freeze (mw=1 in RUN or MWAIT, or state=ERR):
  - StallF=StallD=StallE=StallM=1, FlushW=1; all other flushes 0.
  - Freeze overrides every other source.
- MDU structural hazard (MduStartE & MduBusy, no freeze):
  - StallF=StallD=StallE=1, FlushM=1.
- Data hazard (LoadUseD | (MduUseD & MduBusy), no freeze):
  - StallF=StallD=1, FlushE=1.
- Branch (BranchTakenD, no freeze, StallD=0): FlushD=1.
  - If StallD=1, the flush is suppressed and the branch is re-evaluated next cycle.
- MDU counter:
  - Loads MDU_LAT when MduStartE=1, mdu_cnt=0, StallE=0 and not frozen.
  - Otherwise decrements while non-zero, including during freeze.
  - MduBusy = (mdu_cnt != 0).
- Width rules:
  - mdu_cnt is clog2(MDU_LAT+1) bits; to_cnt is clog2(MEM_TO+1) bits.
  - Neither counter wraps: mdu_cnt stops at 0, to_cnt stops at MEM_TO.

## Timing
- Reset (rst_n low, asynchronous): state=RUN, counters=0, MemErr=0. All outputs are forced to 0 while rst_n=0, regardless of inputs.
- Stall/flush latency: 0 cycles, combinational from inputs and state.
- MemRdyM=1 in the same cycle as MemReqM means no stall at all.
- MduBusy rises the cycle after the start edge and stays high for exactly MDU_LAT cycles.
- A dependent MduUseD issues in the first cycle with MduBusy=0.
- Reset mid-MWAIT or mid-MDU aborts immediately. No pending state survives reset.

## Configuration
- STALL_CNT_EN defined:
  - Adds output port StallCnt (out, 32 bits).
  - StallCnt counts cycles with StallF=1, saturates at 0xFFFFFFFF, and resets to 0.
- STALL_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- LoadUseD=1 for 1 cycle -> StallF=StallD=FlushE=1 that cycle only; FlushD=0 even with BranchTakenD=1.
- MemReqM=1, MemRdyM=0 for 3 cycles then 1 -> StallF..StallM=FlushW=1 for 3 cycles, 0 on the 4th; state returns to RUN; MemErr=0.
- MEM_TO=4, MemReqM=1, MemRdyM held 0 -> MemErr=1 after the 4th wait cycle; freeze persists with MemRdyM=1; rst_n pulse clears everything to 0.
- MDU_LAT=3: MduStartE pulse, then MduUseD=1 -> MduBusy high 3 cycles; StallD=FlushE=1 for those 3 cycles, then released.
- MduStartE while busy with BranchTakenD=1 -> StallE=FlushM=1, FlushD=0; mdu_cnt not reloaded.
- STALL_CNT_EN build: 2 load-use cycles + 3 memory-wait cycles -> StallCnt=5.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Combines load-use hazards, taken branches, a variable-latency data memory
// (with stuck-access timeout) and a fixed-latency MDU into stage-register
// hold/bubble controls. All controls are combinational from registered state
// and current inputs, and are forced low while rst_n is asserted.
// Optional feature macro: STALL_CNT_EN adds a saturating 32-bit StallCnt port.

module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int MEM_TO  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReqM,
    input  logic        MemRdyM,
    input  logic        LoadUseD,
    input  logic        BranchTakenD,
    input  logic        MduStartE,
    input  logic        MduUseD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        StallE,
    output logic        FlushE,
    output logic        StallM,
    output logic        FlushM,
    output logic        FlushW,
    output logic        MduBusy,
    output logic        MemErr
`ifdef STALL_CNT_EN
   ,output logic [31:0] StallCnt
`endif
);

    localparam int MW = $clog2(MDU_LAT + 1);
    localparam int TW = $clog2(MEM_TO + 1);

    typedef enum logic [1:0] {RUN, MWAIT, ERR} HazState;

    HazState       state, stateNext;
    logic [TW-1:0] toCnt, toNext, toInc;
    logic [MW-1:0] mduCnt;
    logic          mw, freeze, mduBusyInt, mduHaz, dataHaz, mduLoad;
    logic          stallFInt, stallDInt, stallEInt;

    assign mw         = MemReqM & ~MemRdyM;
    assign freeze     = (state == ERR) | mw;
    assign mduBusyInt = (mduCnt != '0);
    assign mduHaz     = MduStartE & mduBusyInt & ~freeze;
    assign dataHaz    = (LoadUseD | (MduUseD & mduBusyInt)) & ~freeze;
    assign stallFInt  = freeze | mduHaz | dataHaz;
    assign stallDInt  = stallFInt;
    assign stallEInt  = freeze | mduHaz;
    assign mduLoad    = MduStartE & ~mduBusyInt & ~stallEInt & ~freeze;

    // Memory-wait state register and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            toCnt <= '0;
        end else begin
            state <= stateNext;
            toCnt <= toNext;
        end
    end

    // Next state: enter MWAIT on a blocked access, time out into absorbing ERR
    always_comb begin
        stateNext = state;
        toNext    = toCnt;
        toInc     = (toCnt == TW'(MEM_TO)) ? toCnt : toCnt + TW'(1);
        case (state)
            RUN: begin
                if (mw) begin
                    toNext    = TW'(1);
                    stateNext = (TW'(1) == TW'(MEM_TO)) ? ERR : MWAIT;
                end
            end
            MWAIT: begin
                if (MemRdyM) begin
                    toNext    = '0;
                    stateNext = RUN;
                end else begin
                    toNext = toInc;
                    if (toInc == TW'(MEM_TO)) begin
                        stateNext = ERR;
                    end
                end
            end
            ERR:     stateNext = ERR;
            default: stateNext = RUN;
        endcase
    end

    // MDU busy counter: loads on an accepted start, otherwise drains to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mduCnt <= '0;
        end else if (mduLoad) begin
            mduCnt <= MW'(MDU_LAT);
        end else if (mduBusyInt) begin
            mduCnt <= mduCnt - MW'(1);
        end
    end

    // Stage controls; holding ID/EX wins over bubbling it when both hazards meet
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        FlushD  = 1'b0;
        StallE  = 1'b0;
        FlushE  = 1'b0;
        StallM  = 1'b0;
        FlushM  = 1'b0;
        FlushW  = 1'b0;
        MduBusy = 1'b0;
        MemErr  = 1'b0;
        if (rst_n) begin
            StallF  = stallFInt;
            StallD  = stallDInt;
            FlushD  = BranchTakenD & ~freeze & ~stallDInt;
            StallE  = stallEInt;
            FlushE  = dataHaz & ~stallEInt;
            StallM  = freeze;
            FlushM  = mduHaz;
            FlushW  = freeze;
            MduBusy = mduBusyInt;
            MemErr  = (state == ERR);
        end
    end

`ifdef STALL_CNT_EN
    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
        end else if (StallF && (StallCnt != 32'hFFFF_FFFF)) begin
            StallCnt <= StallCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl with MDU_LAT=3, MEM_TO=4.
// A directed vector table walks one continuous sequence from reset; hand
// sequences then cover reset during ERR, MWAIT and an MDU operation.

module tb_pipe_hazard_ctrl;

    localparam int MDU_LAT = 3;
    localparam int MEM_TO  = 4;

    // in  = {MemReqM, MemRdyM, LoadUseD, BranchTakenD, MduStartE, MduUseD}
    // exp = {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushM, FlushW, MduBusy, MemErr}
    typedef struct {
        logic [5:0] in;
        logic [9:0] exp;
    } VecT;

    localparam logic [9:0] FRZ = 10'b1101010100;

    logic clk, rst_n;
    logic MemReqM, MemRdyM, LoadUseD, BranchTakenD, MduStartE, MduUseD;
    logic StallF, StallD, FlushD, StallE, FlushE, StallM, FlushM, FlushW, MduBusy, MemErr;
    logic [9:0] outs;
`ifdef STALL_CNT_EN
    logic [31:0] StallCnt;
`endif

    int assertCnt = 0;
    int failCnt   = 0;
    VecT vecs[27];

    pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .MEM_TO(MEM_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReqM(MemReqM), .MemRdyM(MemRdyM), .LoadUseD(LoadUseD),
        .BranchTakenD(BranchTakenD), .MduStartE(MduStartE), .MduUseD(MduUseD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .StallE(StallE),
        .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM), .FlushW(FlushW),
        .MduBusy(MduBusy), .MemErr(MemErr)
`ifdef STALL_CNT_EN
       ,.StallCnt(StallCnt)
`endif
    );

    assign outs = {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushM, FlushW, MduBusy, MemErr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        assertCnt++;
        if (act !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic driveInputs(input logic [5:0] in);
        {MemReqM, MemRdyM, LoadUseD, BranchTakenD, MduStartE, MduUseD} = in;
    endtask

    // One cycle: drive after the falling edge, sample before the rising edge
    task automatic applyStimulus(input string name, input logic [5:0] in, input logic [9:0] exp);
        @(negedge clk);
        driveInputs(in);
        #1;
        checkOutput(name, outs, exp);
    endtask

    // Asynchronous reset pulse with live inputs, checking outputs forced low
    task automatic resetPulse(input string name, input logic [5:0] in);
        @(negedge clk);
        driveInputs(in);
        rst_n = 1'b0;
        #1;
        checkOutput({name, "_hold"}, outs, 10'b0);
        @(negedge clk);
        driveInputs(6'b0);
        rst_n = 1'b1;
        #1;
        checkOutput({name, "_post"}, outs, 10'b0);
    endtask

    initial begin
        vecs[0]  = '{in: 6'b000000, exp: 10'b0000000000};
        vecs[1]  = '{in: 6'b001100, exp: 10'b1100100000};
        vecs[2]  = '{in: 6'b000100, exp: 10'b0010000000};
        vecs[3]  = '{in: 6'b000000, exp: 10'b0000000000};
        vecs[4]  = '{in: 6'b100000, exp: FRZ};
        vecs[5]  = '{in: 6'b100000, exp: FRZ};
        vecs[6]  = '{in: 6'b100000, exp: FRZ};
        vecs[7]  = '{in: 6'b110000, exp: 10'b0000000000};
        vecs[8]  = '{in: 6'b000000, exp: 10'b0000000000};
        vecs[9]  = '{in: 6'b111000, exp: 10'b1100100000};
        vecs[10] = '{in: 6'b000010, exp: 10'b0000000000};
        vecs[11] = '{in: 6'b000001, exp: 10'b1100100010};
        vecs[12] = '{in: 6'b000001, exp: 10'b1100100010};
        vecs[13] = '{in: 6'b000001, exp: 10'b1100100010};
        vecs[14] = '{in: 6'b000001, exp: 10'b0000000000};
        vecs[15] = '{in: 6'b000010, exp: 10'b0000000000};
        vecs[16] = '{in: 6'b000110, exp: 10'b1101001010};
        vecs[17] = '{in: 6'b000000, exp: 10'b0000000010};
        vecs[18] = '{in: 6'b000000, exp: 10'b0000000010};
        vecs[19] = '{in: 6'b000000, exp: 10'b0000000000};
        vecs[20] = '{in: 6'b000010, exp: 10'b0000000000};
        vecs[21] = '{in: 6'b100010, exp: 10'b1101010110};
        vecs[22] = '{in: 6'b100000, exp: 10'b1101010110};
        vecs[23] = '{in: 6'b100000, exp: 10'b1101010110};
        vecs[24] = '{in: 6'b100000, exp: FRZ};
        vecs[25] = '{in: 6'b110000, exp: 10'b1101010101};
        vecs[26] = '{in: 6'b001100, exp: 10'b1101010101};

        rst_n = 1'b0;
        driveInputs(6'b001100);
        #1;
        checkOutput("initRst", outs, 10'b0);
        @(negedge clk);
        driveInputs(6'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
        end

        // Reset out of ERR with every hazard input active
        resetPulse("rstErr", 6'b101111);

        // Reset mid-MWAIT: no wait progress may survive into the next access
        applyStimulus("mwA1", 6'b100000, FRZ);
        applyStimulus("mwA2", 6'b100000, FRZ);
        applyStimulus("mwA3", 6'b100000, FRZ);
        resetPulse("rstMwait", 6'b100000);
        applyStimulus("mwB1", 6'b100000, FRZ);
        applyStimulus("mwB2", 6'b100000, FRZ);
        applyStimulus("mwB3", 6'b100000, FRZ);
        applyStimulus("mwBrdy", 6'b110000, 10'b0);

        // Reset mid-MDU operation clears the busy counter
        applyStimulus("mduSt", 6'b000010, 10'b0);
        applyStimulus("mduBusy", 6'b000000, 10'b0000000010);
        resetPulse("rstMdu", 6'b000001);
        applyStimulus("mduAfter", 6'b000001, 10'b0);

`ifdef STALL_CNT_EN
        resetPulse("rstCnt", 6'b0);
        applyStimulus("cntLu1", 6'b001000, 10'b1100100000);
        applyStimulus("cntLu2", 6'b001000, 10'b1100100000);
        applyStimulus("cntMw1", 6'b100000, FRZ);
        applyStimulus("cntMw2", 6'b100000, FRZ);
        applyStimulus("cntMw3", 6'b100000, FRZ);
        applyStimulus("cntRdy", 6'b110000, 10'b0);
        @(negedge clk);
        driveInputs(6'b0);
        #1;
        assertCnt++;
        if (StallCnt !== 32'd5) begin
            failCnt++;
            $display("[TB] FAIL stallCnt: got %0d expected 5", StallCnt);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
